nibble_bank_writer: RTL and testbench
=====================================

Name: nibble_bank_writer

Overview:
- Writer side of the 256-entry x 4-bit packed bus consumed by mux256_4bits.
- Accepts a stream of 4-bit nibbles over a valid/ready handshake and stores each one at an auto-incrementing slot of a 1024-bit register.
- Publishes the register as D_out, which drives mux256_4bits.D directly.
- One write frame starts at base_addr and runs for len nibbles.

Parameters:
- DEPTH, 256, number of nibble slots.
- W, 4, bits per slot.
- AW, 8, slot address width (log2 DEPTH).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  begin frame; sampled only in IDLE.
- base_addr  input  AW  first slot of frame; sampled with start.
- len  input  AW+1  nibbles in frame, 0..256; sampled with start.
- clear  input  1  zero the whole bank; honoured only in IDLE.
- in_valid  input  1  in_data valid.
- in_data  input  W  nibble to store.
- in_ready  output  1  writer accepts a nibble this cycle.
- wr_ptr  output  AW  next slot to be written.
- busy  output  1  high in FILL.
- done  output  1  one-cycle pulse, frame complete.
- D_out  output  DEPTH*W  packed bank; slot k is D_out[4k+3:4k].

Behaviour:
- Reset is synchronous and active-low: rst_n low at a rising edge of clk resets the block.
  - Reset values: D_out=0, wr_ptr=0, remaining=0, state=IDLE, busy=0, done=0, in_ready=0.
  - Reset asserted mid-frame aborts the frame, clears D_out, and produces no done pulse.
- FSM states: IDLE, FILL, DONE. All outputs are decoded from registered state and registers only; no input-to-output combinational paths.
  - in_ready = (state==FILL).
  - busy = (state==FILL).
  - done = (state==DONE).
- IDLE:
  - clear=1: D_out<=0 next cycle. clear has priority over start in the same cycle, and start is dropped.
  - start=1, len!=0: wr_ptr<=base_addr, remaining<=len, next state FILL.
  - start=1, len==0: next state DONE. No writes, wr_ptr unchanged.
- FILL:
  - Handshake occurs on in_valid && in_ready at a rising edge:
    - slot[wr_ptr]<=in_data.
    - wr_ptr<=wr_ptr+1, modulo DEPTH (0xFF wraps to 0x00).
    - remaining<=remaining-1.
  - Handshake with remaining==1: next state DONE.
  - in_valid=0: hold everything.
  - start and clear are ignored.
  - len=256 from any base writes every slot exactly once, and wr_ptr ends equal to base_addr.
- DONE: lasts exactly one cycle with in_ready=0; next state IDLE. start and clear are ignored in DONE.
- Latency:
  - A written nibble is visible on D_out the cycle after its handshake.
  - done rises the cycle after the final handshake.
  - The earliest start for the next frame is the cycle after done.
- Unwritten slots retain their previous values; a frame never disturbs slots outside its range.
- Throughput: one nibble per cycle with in_valid held high.

Decomposition:
- Package nibble_bank_pkg holds:
  - localparams DEPTH, W, AW.
  - typedef enum logic [1:0] state_t {IDLE, FILL, DONE}.
- Sub-module nibble_bank_ctrl holds the FSM, wr_ptr and remaining counter. Its outputs are in_ready, busy, done, a wr_en strobe and wr_ptr.
- The top level keeps the 1024-bit bank and the indexed part-select write D_out[wr_ptr*W +: W].

Test Plan:
1. Reset, then start with base=0, len=8, and stream nibbles D,C,B,A,4,3,2,1 one per cycle -> D_out[31:0]=0x1234ABCD, upper bits 0, done high exactly one cycle after the 8th handshake, wr_ptr=8. A mux256_4bits driven by D_out with sel=0..7 returns Y=D,C,B,A,4,3,2,1.
2. base=0xFE, len=4, nibbles 1,2,3,4 -> slots FE=1, FF=2, 00=3, 01=4; wr_ptr=0x02; all other slots unchanged.
3. len=8 with in_valid toggling 1,0,1,0 -> exactly 8 writes. in_ready stays high through the gaps, and done only follows the 8th accepted beat.
4. start with len=0 -> done pulse next cycle, busy never high, D_out and wr_ptr unchanged.
5. Assert start and clear during FILL -> both ignored and the frame completes normally. In IDLE, clear and start in the same cycle -> D_out=0 next cycle and no frame starts.
6. rst_n low for one cycle after the 3rd of 8 beats -> D_out=0, wr_ptr=0, state IDLE, no done pulse; a subsequent frame works normally.

Source files
------------

// File: rtl/nibble_bank_pkg.sv
// Shared sizes and FSM encoding for the nibble bank writer.
package nibble_bank_pkg;

    localparam int DEPTH = 256;                    // nibble slots
    localparam int W     = 4;                      // bits per slot
    localparam int AW    = 8;                      // slot address width
    localparam int BW    = $clog2(DEPTH * W);      // bit index width into the bank

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/nibble_bank_writer_if.sv
// Nibble stream handshake between a producer and the bank writer.
interface nibble_bank_writer_if;
    import nibble_bank_pkg::*;

    logic         in_valid;
    logic [W-1:0] in_data;
    logic         in_ready;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);

endinterface

// File: rtl/nibble_bank_ctrl.sv
// Frame sequencer: FSM, write pointer and remaining-beat counter.
module nibble_bank_ctrl
    import nibble_bank_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic [AW:0]   len,
    input  logic          clear,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          busy,
    output logic          done,
    output logic          wr_en,
    output logic          clr_en,
    output logic [AW-1:0] wr_ptr
);

    state_t        state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [AW:0]   rem_q, rem_d;

    // Status outputs come straight from the registered state.
    assign in_ready = (state_q == FILL);
    assign busy     = (state_q == FILL);
    assign done     = (state_q == DONE);
    assign wr_ptr   = ptr_q;

    // Write strobe for the bank; clear only takes effect while idle.
    assign wr_en  = (state_q == FILL) && in_valid;
    assign clr_en = (state_q == IDLE) && clear;

    // State, pointer and counter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            rem_q   <= rem_d;
        end
    end

    // Next-state logic; start and clear are only looked at in IDLE.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        rem_d   = rem_q;
        case (state_q)
            IDLE: begin
                if (!clear && start) begin
                    if (len != '0) begin
                        ptr_d   = base_addr;
                        rem_d   = len;
                        state_d = FILL;
                    end else begin
                        // empty frame: go straight to the done pulse
                        state_d = DONE;
                    end
                end
            end
            FILL: begin
                if (in_valid) begin
                    // pointer wraps naturally at DEPTH since it is AW bits
                    ptr_d = ptr_q + AW'(1);
                    rem_d = rem_q - (AW+1)'(1);
                    if (rem_q == (AW+1)'(1)) state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: rtl/nibble_bank_writer.sv
// Packed 256 x 4-bit register bank filled from a nibble stream.
module nibble_bank_writer
    import nibble_bank_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [AW-1:0]        base_addr,
    input  logic [AW:0]          len,
    input  logic                 clear,
    nibble_bank_writer_if.slave  in_if,
    output logic [AW-1:0]        wr_ptr,
    output logic                 busy,
    output logic                 done,
    output logic [DEPTH*W-1:0]   D_out
);

    logic [DEPTH*W-1:0] bank_q;
    logic               wr_en;
    logic               clr_en;
    logic [BW-1:0]      bit_idx;

    nibble_bank_ctrl u_ctrl (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .len       (len),
        .clear     (clear),
        .in_valid  (in_if.in_valid),
        .in_ready  (in_if.in_ready),
        .busy      (busy),
        .done      (done),
        .wr_en     (wr_en),
        .clr_en    (clr_en),
        .wr_ptr    (wr_ptr)
    );

    assign bit_idx = BW'(wr_ptr) * BW'(W);
    assign D_out   = bank_q;

    // Bank storage: one slot written per accepted beat, whole bank cleared on request.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bank_q <= '0;
        end else if (clr_en) begin
            bank_q <= '0;
        end else if (wr_en) begin
            bank_q[bit_idx +: W] <= in_if.in_data;
        end
    end

endmodule

// File: tb/tb_nibble_bank_writer.sv
// Randomized scoreboard bench for nibble_bank_writer.
module tb_nibble_bank_writer;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [7:0]    base_addr;
    logic [8:0]    len;
    logic          clear;
    logic [7:0]    wr_ptr;
    logic          busy;
    logic          done;
    logic [1023:0] D_out;

    nibble_bank_writer_if bus ();

    nibble_bank_writer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .len       (len),
        .clear     (clear),
        .in_if     (bus.slave),
        .wr_ptr    (wr_ptr),
        .busy      (busy),
        .done      (done),
        .D_out     (D_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1023:0] bank;
        logic [7:0]    ptr;
    } exp_t;

    exp_t       sbq[$];
    logic [3:0] mdl[256];
    logic [7:0] mptr;
    logic [3:0] beats[$];
    int         n_cmp = 0;
    int         n_err = 0;

    function automatic logic [1023:0] pack_model();
        logic [1023:0] b;
        b = '0;
        for (int k = 0; k < 256; k++) b[k*4 +: 4] = mdl[k];
        return b;
    endfunction

    function automatic logic [3:0] slot_of(input logic [1023:0] b, input int k);
        return b[k*4 +: 4];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_bank(input string name, input logic [1023:0] act, input logic [1023:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            for (int k = 0; k < 256; k++) begin
                if (slot_of(act, k) !== slot_of(exp, k)) begin
                    $display("FAIL %s: slot 0x%0h got 0x%0h want 0x%0h at %0t",
                             name, k, slot_of(act, k), slot_of(exp, k), $time);
                    break;
                end
            end
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding frame.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && done === 1'b1) begin
            if (sbq.size() == 0) begin
                chk("unexpected_done", 32'(done), 32'd0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk_bank("frame_bank", D_out, e.bank);
                chk("frame_ptr", 32'(wr_ptr), 32'(e.ptr));
            end
        end
    end

    // One frame. gap: 0 = back-to-back, 1 = alternate valid, 2 = random valid.
    // abort_after > 0 pulses reset right after that many accepted beats.
    task automatic run_frame(input logic [7:0] base, input int n, input int gap,
                             input bit inj, input int abort_after);
        int  sent, cyc;
        bit  v, acc;
        while (beats.size() < n) beats.push_back(4'($urandom));

        if (abort_after <= 0) begin
            for (int i = 0; i < n; i++) mdl[8'(int'(base) + i)] = beats[i];
            if (n > 0) mptr = base + 8'(n);
            sbq.push_back('{bank: pack_model(), ptr: mptr});
        end

        @(negedge clk);
        start = 1'b1; base_addr = base; len = 9'(n);
        @(negedge clk);
        start = 1'b0;

        if (n == 0) begin
            chk("zero_len_done", 32'(done), 32'd1);
            chk("zero_len_busy", 32'(busy), 32'd0);
            @(negedge clk);
            chk("zero_len_done_end", 32'(done), 32'd0);
            chk("zero_len_busy_end", 32'(busy), 32'd0);
            beats.delete();
            return;
        end

        sent = 0; cyc = 0;
        while (sent < n && cyc < 4*n + 20) begin
            case (gap)
                0:       v = 1'b1;
                1:       v = (cyc % 2 == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            bus.in_valid = v;
            bus.in_data  = beats[sent];
            if (inj) begin
                start = 1'($urandom); clear = 1'($urandom);
                base_addr = 8'($urandom); len = 9'($urandom_range(0, 256));
            end
            if (!v) chk("ready_in_gap", 32'(bus.in_ready), 32'd1);
            acc = v && bus.in_ready;
            @(negedge clk);
            cyc++;
            if (acc) begin
                chk("beat_visible", 32'(slot_of(D_out, int'(base) + sent & 255)), 32'(beats[sent]));
                sent++;
                if (sent == abort_after) begin
                    bus.in_valid = 1'b0; start = 1'b0; clear = 1'b0;
                    rst_n = 1'b0;
                    @(negedge clk);
                    rst_n = 1'b1;
                    for (int k = 0; k < 256; k++) mdl[k] = 4'h0;
                    mptr = 8'h00;
                    chk_bank("abort_bank", D_out, '0);
                    chk("abort_ptr", 32'(wr_ptr), 32'd0);
                    chk("abort_busy", 32'(busy), 32'd0);
                    chk("abort_ready", 32'(bus.in_ready), 32'd0);
                    for (int k = 0; k < 4; k++) begin
                        chk("abort_no_done", 32'(done), 32'd0);
                        @(negedge clk);
                    end
                    beats.delete();
                    return;
                end
            end
            if (sent < n) chk("early_done", 32'(done), 32'd0);
        end
        bus.in_valid = 1'b0; start = 1'b0; clear = 1'b0;

        if (sent < n) begin
            chk("frame_timeout", 32'(sent), 32'(n));
        end else begin
            chk("done_after_last", 32'(done), 32'd1);
            chk("done_ready_low", 32'(bus.in_ready), 32'd0);
            @(negedge clk);
            chk("done_one_cycle", 32'(done), 32'd0);
            chk("idle_busy", 32'(busy), 32'd0);
        end
        beats.delete();
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; base_addr = '0; len = '0; clear = 1'b0;
        bus.in_valid = 1'b0; bus.in_data = '0;
        for (int k = 0; k < 256; k++) mdl[k] = 4'h0;
        mptr = 8'h00;
        repeat (2) @(negedge clk);
        chk_bank("reset_bank", D_out, '0);
        chk("reset_ptr", 32'(wr_ptr), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_ready", 32'(bus.in_ready), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Known pattern at the bottom of the bank.
        beats = '{4'hD, 4'hC, 4'hB, 4'hA, 4'h4, 4'h3, 4'h2, 4'h1};
        run_frame(8'h00, 8, 0, 1'b0, 0);
        chk("pattern_low_word", D_out[31:0], 32'h1234ABCD);
        chk("pattern_upper_zero", 32'(D_out[1023:32] == '0), 32'd1);
        chk("pattern_ptr", 32'(wr_ptr), 32'd8);

        // Wrap across the top of the bank.
        beats = '{4'h1, 4'h2, 4'h3, 4'h4};
        run_frame(8'hFE, 4, 0, 1'b0, 0);
        chk("wrap_ptr", 32'(wr_ptr), 32'h02);
        chk("wrap_slot_ff", 32'(slot_of(D_out, 255)), 32'h2);
        chk("wrap_slot_00", 32'(slot_of(D_out, 0)), 32'h3);

        // Valid toggling, then empty frame.
        run_frame(8'h40, 8, 1, 1'b0, 0);
        run_frame(8'h77, 0, 0, 1'b0, 0);
        chk("zero_len_ptr", 32'(wr_ptr), 32'(mptr));

        // start/clear pokes during FILL must be ignored.
        run_frame(8'h90, 12, 2, 1'b1, 0);

        // clear beats start while idle.
        @(negedge clk);
        clear = 1'b1; start = 1'b1; base_addr = 8'h10; len = 9'd5;
        @(negedge clk);
        clear = 1'b0; start = 1'b0;
        for (int k = 0; k < 256; k++) mdl[k] = 4'h0;
        chk_bank("clear_bank", D_out, '0);
        chk("clear_no_start", 32'(busy), 32'd0);
        @(negedge clk);
        chk("clear_still_idle", 32'(bus.in_ready), 32'd0);

        // Reset after the third beat, then a normal frame.
        run_frame(8'h20, 8, 0, 1'b0, 3);
        run_frame(8'h05, 6, 0, 1'b0, 0);

        // Full-bank frame from an odd base.
        run_frame(8'hC3, 256, 0, 1'b0, 0);
        chk("full_ptr_back", 32'(wr_ptr), 32'hC3);

        // Random frames.
        for (int f = 0; f < 25; f++) begin
            int n;
            n = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 24));
            run_frame(8'($urandom), n, int'($urandom_range(0, 2)), 1'($urandom), 0);
        end

        repeat (4) @(negedge clk);
        chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Absolute safety bound.
    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, want finish before %0t", $time);
        $fatal(1);
    end

endmodule
